// File: rtl/conv_tile_sequencer.sv
// Layer sequencer for the 16-PE convolution datapath: frames each window (pixel x filter pass),
// waits for all PE results and drains the 16 activated bytes to the OFM buffer as four words.
module conv_tile_sequencer #(
  parameter int unsigned KERNEL_W = 3,
  parameter int unsigned IFM_C    = 16,
  parameter int unsigned OFM_W    = 54,
  parameter int unsigned OFM_C    = 32,
  parameter int unsigned BRAM_LAT = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         addr_gen_ready,
  output logic [7:0]   filter_pass,
  output logic [15:0]  pixel_idx,
  output logic [15:0]  PE_reset,
  output logic [15:0]  PE_finish,
  input  logic [15:0]  valid,
  input  logic [127:0] ofm_in,
  output logic         ofm_we,
  input  logic         ofm_ready,
  output logic [15:0]  ofm_addr,
  output logic [31:0]  ofm_data
);

  localparam int unsigned WIN_WORDS = KERNEL_W * KERNEL_W * IFM_C / 4;
  localparam int unsigned NPIX      = OFM_W * OFM_W;
  localparam int unsigned NPASS     = OFM_C / 16;
  localparam int unsigned WPP       = OFM_C / 4;
  localparam int unsigned LAST_FEED = BRAM_LAT + WIN_WORDS - 1;
  localparam logic [15:0] LAST_PIX  = 16'(NPIX - 1);
  localparam logic [7:0]  LAST_PASS = 8'(NPASS - 1);

  typedef enum logic [2:0] {StIdle, StPrime, StFeed, StWait, StDrain, StNext, StDone} state_e;

  state_e       r_state;
  logic [31:0]  r_cnt;
  logic [31:0]  r_tmo;
  logic [1:0]   r_beat;
  logic [127:0] r_hold;

  logic [31:0]  w_cnt_nx;
  logic [31:0]  w_tmo_nx;
  logic [1:0]   w_beat_nx;
  logic         w_all_valid;
  logic [15:0]  w_base;

  assign w_cnt_nx    = r_cnt + 32'd1;
  assign w_tmo_nx    = r_tmo + 32'd1;
  assign w_beat_nx   = r_beat + 2'd1;
  assign w_all_valid = (valid == 16'hFFFF);
  // 16-bit modular arithmetic gives the same result as full precision truncated to 16 bits
  assign w_base      = pixel_idx * 16'(WPP) + {6'd0, filter_pass, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_tmo          <= '0;
      r_beat         <= '0;
      r_hold         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      addr_gen_ready <= 1'b0;
      filter_pass    <= '0;
      pixel_idx      <= '0;
      PE_reset       <= '0;
      PE_finish      <= '0;
      ofm_we         <= 1'b0;
      ofm_addr       <= '0;
      ofm_data       <= '0;
    end else begin
      PE_reset       <= '0;
      PE_finish      <= '0;
      addr_gen_ready <= 1'b0;
      done           <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state        <= StPrime;
            r_cnt          <= '0;
            busy           <= 1'b1;
            error          <= 1'b0;
            pixel_idx      <= '0;
            filter_pass    <= '0;
            PE_reset       <= 16'hFFFF;
            addr_gen_ready <= 1'b1;
          end
        end
        // r_cnt numbers the cycles since PRIME entry; outputs are set for the cycle about to start
        StPrime, StFeed: begin
          if (r_cnt == LAST_FEED) begin
            r_state <= StWait;
            r_tmo   <= '0;
          end else begin
            r_cnt          <= w_cnt_nx;
            r_state        <= (w_cnt_nx < BRAM_LAT) ? StPrime : StFeed;
            PE_reset       <= (w_cnt_nx < BRAM_LAT) ? 16'hFFFF : 16'h0000;
            addr_gen_ready <= (w_cnt_nx < WIN_WORDS);
            PE_finish      <= (w_cnt_nx == LAST_FEED) ? 16'hFFFF : 16'h0000;
          end
        end
        StWait: begin
          if (w_all_valid) begin
            r_hold   <= ofm_in;
            r_beat   <= '0;
            ofm_we   <= 1'b1;
            ofm_data <= ofm_in[31:0];
            ofm_addr <= w_base;
            r_state  <= StDrain;
          end else if (w_tmo_nx >= TIMEOUT) begin
            error       <= 1'b1;
            busy        <= 1'b0;
            pixel_idx   <= '0;
            filter_pass <= '0;
            r_state     <= StIdle;
          end else begin
            r_tmo <= w_tmo_nx;
          end
        end
        StDrain: begin
          if (ofm_ready) begin
            if (r_beat == 2'd3) begin
              ofm_we   <= 1'b0;
              ofm_data <= '0;
              ofm_addr <= '0;
              r_state  <= StNext;
            end else begin
              r_beat   <= w_beat_nx;
              ofm_data <= r_hold[{w_beat_nx, 5'd0} +: 32];
              ofm_addr <= w_base + {14'd0, w_beat_nx};
            end
          end
        end
        StNext: begin
          if (pixel_idx == LAST_PIX && filter_pass == LAST_PASS) begin
            done    <= 1'b1;
            r_state <= StDone;
          end else begin
            if (pixel_idx == LAST_PIX) begin
              pixel_idx   <= '0;
              filter_pass <= filter_pass + 8'd1;
            end else begin
              pixel_idx <= pixel_idx + 16'd1;
            end
            r_state        <= StPrime;
            r_cnt          <= '0;
            PE_reset       <= 16'hFFFF;
            addr_gen_ready <= 1'b1;
          end
        end
        StDone: begin
          busy        <= 1'b0;
          pixel_idx   <= '0;
          filter_pass <= '0;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Randomised bench for conv_tile_sequencer: a queue-based layer model feeds a scoreboard that a
// negedge monitor checks against window framing, OFM writes, done and error behaviour.
module tb_conv_tile_sequencer;
  localparam int unsigned KW = 3, IC = 16, OW = 2, OC = 32, BL = 1, TO = 255;
  localparam int unsigned WIN = KW * KW * IC / 4;
  localparam int unsigned NPIX = OW * OW;
  localparam int unsigned NPASS = OC / 16;
  localparam int unsigned WPP = OC / 4;

  logic clk = 1'b0;
  logic reset, start, busy, done, error, addr_gen_ready, ofm_we, ofm_ready;
  logic [7:0] filter_pass;
  logic [15:0] pixel_idx, PE_reset, PE_finish, valid, ofm_addr;
  logic [127:0] ofm_in;
  logic [31:0] ofm_data;

  always #5 clk = ~clk;

  conv_tile_sequencer #(
    .KERNEL_W(KW), .IFM_C(IC), .OFM_W(OW), .OFM_C(OC), .BRAM_LAT(BL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .addr_gen_ready(addr_gen_ready), .filter_pass(filter_pass), .pixel_idx(pixel_idx),
    .PE_reset(PE_reset), .PE_finish(PE_finish), .valid(valid), .ofm_in(ofm_in),
    .ofm_we(ofm_we), .ofm_ready(ofm_ready), .ofm_addr(ofm_addr), .ofm_data(ofm_data)
  );

  typedef struct { int pass; int pix; } win_t;
  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;
  win_t win_q[$];
  win_t resp_q[$];
  wr_t  sb_q[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, fin_cyc = 0;
  int n_wr = 0, n_done = 0, n_fin = 0, acc_win = 0;
  int rdy_mode = 0, stall_left = 5;
  bit tmo_mode = 1'b0;
  event ev_fin;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input bit ok, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk(name, act == exp, act, exp);
  endtask

  // Layer model: filter pass outer loop, pixel inner loop
  task automatic push_layer();
    win_t w;
    for (int p = 0; p < int'(NPASS); p++)
      for (int x = 0; x < int'(NPIX); x++) begin
        w.pass = p; w.pix = x;
        win_q.push_back(w);
        resp_q.push_back(w);
      end
  endtask

  task automatic flush();
    win_q.delete(); resp_q.delete(); sb_q.delete();
  endtask

  task automatic check_idle(input string tag);
    eq({tag, "_busy"}, busy, 0);
    eq({tag, "_ofm_we"}, ofm_we, 0);
    eq({tag, "_counters"}, {filter_pass, pixel_idx}, 0);
    eq({tag, "_pe_ctl"}, {PE_reset, PE_finish, addr_gen_ready, done}, 0);
    eq({tag, "_ofm_bus"}, {ofm_addr, ofm_data}, 0);
  endtask

  // Monitor
  bit in_frame = 1'b0;
  logic [15:0] prev_pe_reset = '0;
  int agr_n = 0, rst_n = 0, win_cyc = 0;
  always @(negedge clk) begin : mon
    win_t w;
    wr_t e;
    if (reset) begin
      in_frame = 1'b0;
      prev_pe_reset = '0;
    end else begin
      if (PE_reset == 16'hFFFF && prev_pe_reset == 16'h0000) begin
        chk("window_expected", win_q.size() > 0, win_q.size(), 1);
        if (win_q.size() > 0) begin
          w = win_q.pop_front();
          eq("window_order", {filter_pass, pixel_idx}, {8'(w.pass), 16'(w.pix)});
        end
        in_frame = 1'b1; agr_n = 0; rst_n = 0; win_cyc = 0; acc_win = 0;
      end
      if (in_frame) begin
        if (addr_gen_ready) agr_n++;
        if (PE_reset == 16'hFFFF) rst_n++;
        if (PE_finish == 16'hFFFF) begin
          eq("finish_position", win_cyc, BL + WIN - 1);
          eq("agr_cycles", agr_n, WIN);
          eq("pe_reset_cycles", rst_n, BL);
          in_frame = 1'b0;
          fin_cyc = cyc;
          n_fin++;
          -> ev_fin;
        end
        win_cyc++;
      end else if (addr_gen_ready || PE_finish != 16'h0000) begin
        chk("stray_framing", 1'b0, {addr_gen_ready, PE_finish}, 0);
      end
      if (ofm_we) begin
        chk("write_expected", sb_q.size() > 0, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          e = sb_q[0];
          eq("ofm_addr", ofm_addr, e.addr);
          eq("ofm_data", ofm_data, e.data);
          if (ofm_ready) begin
            void'(sb_q.pop_front());
            n_wr++;
            acc_win++;
          end
        end
      end
      if (done) begin
        n_done++;
        eq("writes_left_at_done", sb_q.size(), 0);
        eq("windows_left_at_done", win_q.size(), 0);
      end
      prev_pe_reset = PE_reset;
    end
  end

  // Responder: answers each window with all-valid V cycles after WAIT entry
  initial begin : resp
    int v;
    win_t w;
    wr_t e;
    logic [7:0] by [16];
    valid = '0; ofm_in = '0;
    forever begin
      @(ev_fin);
      @(posedge clk); #1;
      if (tmo_mode) begin
        valid = 16'h7FFF;
        ofm_in = {$urandom, $urandom, $urandom, $urandom};
        wait (!tmo_mode);
        @(posedge clk); #1;
        valid = '0;
      end else begin
        v = $urandom_range(0, 4);
        repeat (v) begin
          valid = 16'($urandom_range(0, 65534));
          ofm_in = {$urandom, $urandom, $urandom, $urandom};
          @(posedge clk); #1;
        end
        w.pass = 0; w.pix = 0;
        if (resp_q.size() > 0) w = resp_q.pop_front();
        for (int k = 0; k < 16; k++) begin
          by[k] = 8'($urandom);
          ofm_in[8*k +: 8] = by[k];
        end
        for (int b = 0; b < 4; b++) begin
          e.addr = 16'(w.pix * WPP + w.pass * 4 + b);
          e.data = {by[4*b+3], by[4*b+2], by[4*b+1], by[4*b]};
          sb_q.push_back(e);
        end
        valid = 16'hFFFF;
        @(posedge clk); #1;
        valid = '0; ofm_in = '0;
      end
    end
  end

  // OFM ready: 0 always, 1 random, 2 five-cycle stall on beat 2 of every window
  initial begin : rdy
    ofm_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: ofm_ready = 1'b1;
        1: ofm_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (ofm_we && acc_win == 2 && stall_left > 0) begin
            ofm_ready = 1'b0;
            stall_left--;
          end else begin
            ofm_ready = 1'b1;
            if (!(ofm_we && acc_win == 2)) stall_left = 5;
          end
        end
      endcase
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_layer(input int mode, input bit poke);
    int d0, w0, t;
    d0 = n_done; w0 = n_wr;
    rdy_mode = mode;
    push_layer();
    pulse_start();
    if (poke) begin
      repeat (20) @(posedge clk);
      #1; pulse_start();
      repeat (150) @(posedge clk);
      #1; pulse_start();
    end
    t = 0;
    while (n_done == d0 && t < 20000) begin @(posedge clk); t++; end
    eq("layer_done_count", n_done - d0, 1);
    eq("layer_writes", n_wr - w0, NPIX * NPASS * 4);
    eq("layer_windows_left", win_q.size(), 0);
    @(negedge clk);
    eq("after_done_busy", busy, 0);
    eq("done_one_cycle", done, 0);
    flush();
  endtask

  initial begin : main
    int t, w0, d0, f0;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    eq("reset_error", error, 0);

    @(posedge clk); #1;
    run_layer(1, 1'b1);
    @(posedge clk); #1;
    run_layer(2, 1'b0);

    // Timeout with a partial valid held
    @(posedge clk); #1;
    tmo_mode = 1'b1; rdy_mode = 0;
    w0 = n_wr; d0 = n_done; f0 = n_fin;
    push_layer();
    pulse_start();
    t = 0;
    while (n_fin == f0 && t < 500) begin @(posedge clk); t++; end
    chk("tmo_window_finished", n_fin != f0, n_fin - f0, 1);
    t = 0;
    @(negedge clk);
    while (!error && t < 1000) begin @(negedge clk); t++; end
    eq("tmo_latency", cyc - fin_cyc, TO + 1);
    eq("tmo_busy", busy, 0);
    eq("tmo_counters", {filter_pass, pixel_idx, ofm_we}, 0);
    repeat (5) @(negedge clk);
    eq("tmo_no_writes", n_wr - w0, 0);
    eq("tmo_no_done", n_done - d0, 0);
    eq("tmo_error_sticky", error, 1);
    tmo_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1; flush();

    // New start clears error; then reset during DRAIN beat 1
    rdy_mode = 0;
    push_layer();
    pulse_start();
    @(negedge clk);
    eq("start_clears_error", error, 0);
    eq("start_sets_busy", busy, 1);
    @(posedge clk); #1;
    t = 0;
    while (!(ofm_we && acc_win == 1) && t < 2000) begin @(posedge clk); #1; t++; end
    chk("reached_drain_beat1", t < 2000, t, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    flush();

    @(posedge clk); #1;
    run_layer(1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
